// File: rtl/uart_pkg.sv
// Shared types and constants for the console UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with same-edge push/pop, registered full/empty flags and
// a first-word-fall-through read port (dout always shows the head entry).
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic                  full_q;
    logic                  empty_q;
    logic                  push_ok;
    logic                  pop_ok;

    // A full FIFO still accepts a push when a pop frees the slot on the same edge.
    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Storage write; head read is combinational so the old head is seen on a shared edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Pointers, count and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_DEPTH);
            empty_q <= (count_d == '0);
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Console UART transmitter: buffers store bytes from the core and sends them
// as 8N1 serial. There is no backpressure, so writes into a full FIFO are
// dropped and remembered in a sticky overflow flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT    = 868,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] uart_din,
    input  logic        uart_we,
    output logic        txd,
    output logic        busy,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        LAST_BIT  = 3'(FRAME_BITS - 3);
    localparam logic [FIFO_DEPTH_LOG2:0] FIFO_CAP = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

    tx_state_t            state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           shift_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 overflow_q;

    logic [7:0]           fifo_dout;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                 fifo_pop;
    logic                 baud_end;
    logic                 drop;
    logic                 unused_din;

    // Only the low byte goes on the line.
    assign unused_din = ^uart_din[31:8];

    assign baud_end = (baud_q == BAUD_LAST);

    // Pop when leaving IDLE, or at the end of a stop bit to chain frames without a gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_end));

    assign drop = uart_we && !fifo_pop && (fifo_count == FIFO_CAP);

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (uart_we),
        .pop   (fifo_pop),
        .din   (uart_din[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame sequencer: baud timing, LSB-first shifting and registered txd/busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        shift_q <= fifo_dout;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        baud_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        txd_q     <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q    <= '0;
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (fifo_pop) begin
                            shift_q <= fifo_dout;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky record of any dropped write; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign txd      = txd_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a serial-line monitor and byte scoreboard.
module tb_uart_tx_fifo;

    localparam int unsigned CPB = 4;
    localparam int unsigned DLOG2 = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] uart_din = '0;
    logic        uart_we = 1'b0;
    logic        txd;
    logic        busy;
    logic        fifo_empty;
    logic        fifo_full;
    logic        overflow;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    logic [7:0] sb[$];
    int         starts[$];

    uart_tx_fifo #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DLOG2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_din   (uart_din),
        .uart_we    (uart_we),
        .txd        (txd),
        .busy       (busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        uart_we = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        sb.delete();
        starts.delete();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", (n < budget) ? 32'd1 : 32'd0, 32'd1);
        check("drain_sb_empty", sb.size(), 0);
    endtask

    // Line monitor: detect start bit, sample each bit at its centre, score the byte.
    initial begin
        bit       active = 1'b0;
        int       cnt = 0;
        logic [7:0] rx = '0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else if (!active) begin
                if (txd === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    starts.push_back(cyc);
                end
            end else begin
                cnt++;
                if (cnt == 2) begin
                    check("start_bit", {31'd0, txd}, 32'd0);
                end else if (cnt >= 6 && cnt <= 34 && ((cnt - 2) % 4) == 0) begin
                    rx = {txd, rx[7:1]};
                end else if (cnt == 38) begin
                    check("stop_bit", {31'd0, txd}, 32'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
                    end else begin
                        exp = sb.pop_front();
                        check("rx_byte", {24'd0, rx}, {24'd0, exp});
                    end
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        // Test 1: reset state held while idle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            check("idle_outputs", {27'd0, txd, busy, fifo_empty, fifo_full, overflow},
                  {27'd0, 5'b10100});
            tick();
        end

        // Test 2: single byte, exact start latency and frame length.
        do_reset();
        uart_we = 1'b1;
        uart_din = 32'h1234_56A5;
        sb.push_back(8'hA5);
        tick();                                   // E0
        uart_we = 1'b0;
        check("t2_after_e0_txd", {31'd0, txd}, 32'd1);
        check("t2_after_e0_empty", {31'd0, fifo_empty}, 32'd0);
        tick();                                   // E1
        check("t2_after_e1_txd", {31'd0, txd}, 32'd0);
        check("t2_after_e1_busy", {31'd0, busy}, 32'd1);
        check("t2_after_e1_empty", {31'd0, fifo_empty}, 32'd1);
        repeat (39) tick();                       // E40
        check("t2_last_cycle_busy", {31'd0, busy}, 32'd1);
        check("t2_last_cycle_txd", {31'd0, txd}, 32'd1);
        tick();                                   // E41
        check("t2_busy_fall", {31'd0, busy}, 32'd0);
        drain(100);

        // Test 3: two back-to-back frames.
        do_reset();
        uart_we = 1'b1;
        uart_din = 32'h41;
        sb.push_back(8'h41);
        tick();
        uart_din = 32'h42;
        sb.push_back(8'h42);
        tick();
        uart_we = 1'b0;
        drain(200);
        check("t3_frame_count", starts.size(), 2);
        if (starts.size() == 2) begin
            check("t3_period", starts[1] - starts[0], 40);
        end

        // Test 4: overflow on the sixth write.
        do_reset();
        uart_we = 1'b1;
        for (int i = 0; i < 6; i++) begin
            uart_din = 32'(i);
            if (i < 5) sb.push_back(8'(i));
            tick();
            if (i == 4) begin
                check("t4_full_after_e4", {31'd0, fifo_full}, 32'd1);
                check("t4_no_ovf_after_e4", {31'd0, overflow}, 32'd0);
            end
        end
        uart_we = 1'b0;
        tick();                                   // E6
        check("t4_ovf_after_e6", {31'd0, overflow}, 32'd1);
        drain(400);
        check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Test 5: push lands on the stop-bit-end pop while full.
        do_reset();
        uart_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            uart_din = 32'h60 + 32'(i);
            sb.push_back(8'h60 + 8'(i));
            tick();                               // E0..E4
        end
        uart_we = 1'b0;
        repeat (36) tick();                       // E40
        check("t5_full_before", {31'd0, fifo_full}, 32'd1);
        uart_we = 1'b1;
        uart_din = 32'h65;
        sb.push_back(8'h65);
        tick();                                   // E41: pop and push together
        uart_we = 1'b0;
        check("t5_full_kept", {31'd0, fifo_full}, 32'd1);
        check("t5_no_ovf", {31'd0, overflow}, 32'd0);
        drain(400);
        check("t5_no_ovf_end", {31'd0, overflow}, 32'd0);

        // Test 6: reset during DATA bit 3 of 0x5A with two bytes queued.
        do_reset();
        uart_we = 1'b1;
        uart_din = 32'h5A;
        tick();                                   // E0
        uart_din = 32'h11;
        tick();                                   // E1
        uart_din = 32'h22;
        tick();                                   // E2
        uart_we = 1'b0;
        repeat (15) tick();                       // E17, inside bit 3
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("t6_post_reset", {28'd0, txd, busy, fifo_empty, overflow}, {28'd0, 4'b1010});
        for (int i = 0; i < 60; i++) begin
            tick();
            check("t6_quiet", {30'd0, txd, busy}, {30'd0, 2'b10});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Downstream consumer of the core's console output. It accepts the byte-write strobe and 32-bit data word that the core's data memory emits on store to the UART address. It buffers the low bytes in a FIFO and serializes them as 8N1 asynchronous serial on a single txd pin. The core has no backpressure path, so overflow is dropped and flagged rather than stalled.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH_LOG2, 4, FIFO holds 2**FIFO_DEPTH_LOG2 bytes

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
uart_din  input  32  data word from core; only bits [7:0] transmitted
uart_we  input  1  one-cycle write strobe; enqueues uart_din[7:0]
txd  output  1  serial line, idle high
busy  output  1  high while a frame is on the line
fifo_empty  output  1  FIFO holds no bytes
fifo_full  output  1  FIFO holds 2**FIFO_DEPTH_LOG2 bytes
overflow  output  1  sticky: a write was dropped

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset values: txd=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0, FSM=IDLE, FIFO pointers and count=0, baud and bit counters=0.
- A reset asserted mid-frame aborts the frame. txd returns to 1 on the next edge, and FIFO contents are discarded.
- FIFO rules:
  - A write occurs on each edge where uart_we=1. The byte is stored unless the FIFO is full and no pop happens on the same edge.
  - A write and a pop on the same edge, including when the FIFO is full, both take effect and the count is unchanged.
  - A write while full with no pop is dropped, and overflow is set to 1. overflow is cleared only by reset.
  - Pointers wrap modulo depth. fifo_full and fifo_empty are registered and derived from a count of width FIFO_DEPTH_LOG2+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into shift_reg, set txd<=0 and busy<=1, clear the baud counter, and go to START.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then set txd<=shift_reg[0], clear bit_cnt, and go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles, sent LSB first. At each bit end, shift right and increment bit_cnt. After bit 7 ends, set txd<=1 and go to STOP.
  - STOP: hold txd=1 for CLKS_PER_BIT cycles. At its end, if the FIFO is non-empty, pop and go directly to START with txd<=0 (no idle gap). Otherwise go to IDLE with busy<=0.
- Latency: for a write sampled on edge E0 into an idle, empty block, txd falls after edge E1. The frame is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have a period of exactly 10*CLKS_PER_BIT.
- The baud counter counts 0..CLKS_PER_BIT-1, and the bit end is at count CLKS_PER_BIT-1. Its width is $clog2(CLKS_PER_BIT).
- uart_din[31:8] is ignored. txd is driven from a flop (no combinational glitches).

Decomposition:
- Package uart_pkg: tx_state_t enum (IDLE, START, DATA, STOP) and the constant FRAME_BITS=10.
- One sub-module, sync_fifo: parameterized width and depth, same-edge push/pop, full/empty/count outputs.
- uart_tx_fifo contains the FSM, baud counter, shift register and overflow flag.

Test Plan:
All tests use CLKS_PER_BIT=4 and FIFO_DEPTH_LOG2=2.
1. Reset then idle 20 cycles -> txd=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0 throughout.
2. Single write uart_din=0x123456A5 at E0 -> txd low from E1 for 4 cycles. Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop 1 for 4 cycles. busy falls after 40 cycles, and fifo_empty returns to 1 after E1.
3. Writes 0x41, 0x42 on consecutive edges -> two frames back to back, with the second start bit beginning exactly 40 cycles after the first. txd is never high between the first stop and second start. Bytes decode as 0x41 then 0x42.
4. Six writes 0x00..0x05 on consecutive edges E0..E5 -> byte 0 is popped at E1, and bytes 1..4 fill the FIFO (fifo_full=1 after E4). Byte 5 is dropped, and overflow=1 from E6 and stays set. The line carries 0x00..0x04 only.
5. FIFO full while a frame's stop bit ends and a write lands on the same edge -> pop and push both occur, fifo_full stays 1, overflow stays 0, and no byte is lost.
6. Reset asserted during DATA bit 3 of byte 0x5A with 2 bytes queued -> txd=1, busy=0, fifo_empty=1 after the reset edge. No further frames are sent, and overflow=0.
